// File: rtl/pc_fetch_unit.sv
// pc_fetch_unit: fetch-stage PC sequencer with return-address stack and halt.
//   Params : PC_RESET (PC after reset), RAS_DEPTH (stack entries, power of two >= 2)
//   Inputs : clock, reset_n (sync, active low), en_fetch, sig_pc_src[1:0],
//            imm_i[31:0], imm_j[31:0], push_ret, halt_req
//   Outputs: pc[31:0], halted, ras_empty, ras_full, ras_overflow, ras_underflow
//   Build  : PC_FETCH_RAS_EN selects the full stack; otherwise a single link register.
module pc_fetch_unit #(
  parameter logic [31:0] PC_RESET = 32'd0,
  parameter int RAS_DEPTH = 8
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        en_fetch,
  input  logic [1:0]  sig_pc_src,
  input  logic [31:0] imm_i,
  input  logic [31:0] imm_j,
  input  logic        push_ret,
  input  logic        halt_req,
  output logic [31:0] pc,
  output logic        halted,
  output logic        ras_empty,
  output logic        ras_full,
  output logic        ras_overflow,
  output logic        ras_underflow
);
  typedef enum logic {RUN, HALT} state_t;
  state_t state_q, state_d;
  logic ev, pop, push, ovf_set, unf_set, empty_d, full_d;
  logic [31:0] pc_inc, ret, pc_d;
  if (RAS_DEPTH < 2 || (RAS_DEPTH & (RAS_DEPTH - 1)) != 0) begin : g_bad_depth
    $error("RAS_DEPTH must be a power of two and at least 2");
  end
  assign ev = en_fetch && state_q == RUN;
  assign pop = ev && sig_pc_src == 2'b11;
  assign push = ev && push_ret;
  assign pc_inc = pc + 32'd1;
  assign halted = state_q == HALT;
  always_comb begin
    state_d = state_q;
    pc_d = pc;
    if (ev) begin
      state_d = halt_req ? HALT : RUN;
      pc_d = sig_pc_src == 2'b00 ? pc_inc :
             sig_pc_src == 2'b01 ? pc + imm_i :
             sig_pc_src == 2'b10 ? pc + imm_j : ret;
    end
  end
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_q <= RUN;
      pc <= PC_RESET;
      ras_empty <= 1'b1;
      ras_full <= 1'b0;
      ras_overflow <= 1'b0;
      ras_underflow <= 1'b0;
    end else begin
      state_q <= state_d;
      pc <= pc_d;
      ras_empty <= empty_d;
      ras_full <= full_d;
      ras_overflow <= ras_overflow | ovf_set;
      ras_underflow <= ras_underflow | unf_set;
    end
  end
`ifdef PC_FETCH_RAS_EN
  localparam int PW = $clog2(RAS_DEPTH);
  localparam int CW = $clog2(RAS_DEPTH + 1);
  logic [31:0] stk [RAS_DEPTH];
  logic [PW-1:0] sp, sp_d, sp_dec, wr_idx;
  logic [CW-1:0] cnt, cnt_d;
  logic has, full;
  assign sp_dec = sp - PW'(1);
  assign has = cnt != '0;
  assign full = cnt == CW'(RAS_DEPTH);
  // An empty pop falls through to the sequential address.
  assign ret = has ? stk[sp_dec] : pc_inc;
  // A pop-and-push reuses the slot the pop just freed.
  assign wr_idx = pop && has ? sp_dec : sp;
  assign empty_d = cnt_d == '0;
  assign full_d = cnt_d == CW'(RAS_DEPTH);
  always_comb begin
    sp_d = sp;
    cnt_d = cnt;
    ovf_set = 1'b0;
    unf_set = pop && !has;
    if (pop && has && !push) begin
      sp_d = sp_dec;
      cnt_d = cnt - CW'(1);
    end else if (push && !(pop && has)) begin
      // When full the pointer wraps onto the oldest entry, so depth saturates.
      sp_d = sp + PW'(1);
      cnt_d = full ? cnt : cnt + CW'(1);
      ovf_set = full;
    end
  end
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      sp <= '0;
      cnt <= '0;
    end else begin
      sp <= sp_d;
      cnt <= cnt_d;
    end
  end
  always_ff @(posedge clock) begin
    if (reset_n && push) stk[wr_idx] <= pc_inc;
  end
`else
  logic [31:0] lr;
  logic lv, lv_d;
  assign ret = lv ? lr : pc_inc;
  assign unf_set = pop && !lv;
  assign ovf_set = push && !pop && lv;
  assign lv_d = push || (lv && !pop);
  assign empty_d = !lv_d;
  assign full_d = lv_d;
  always_ff @(posedge clock) begin
    if (!reset_n) lv <= 1'b0;
    else lv <= lv_d;
  end
  always_ff @(posedge clock) begin
    if (reset_n && push) lr <= pc_inc;
  end
`endif
endmodule

// File: tb/tb_pc_fetch_unit.sv
// tb_pc_fetch_unit: randomized and directed checks of pc_fetch_unit against a queue-based model.
module tb_pc_fetch_unit;
`ifdef PC_FETCH_RAS_EN
  localparam int CAP = 8;
`else
  localparam int CAP = 1;
`endif
  logic clock = 1'b0, reset_n = 1'b0, en_fetch = 1'b0, push_ret = 1'b0, halt_req = 1'b0;
  logic [1:0] sig_pc_src = 2'b00;
  logic [31:0] imm_i = '0, imm_j = '0;
  logic [31:0] pc;
  logic halted, ras_empty, ras_full, ras_overflow, ras_underflow;
  int checks = 0, failures = 0;
  logic [31:0] m_pc;
  bit m_halt, m_ovf, m_unf;
  logic [31:0] m_q[$];

  pc_fetch_unit #(.PC_RESET(32'd0), .RAS_DEPTH(8)) dut (
    .clock(clock), .reset_n(reset_n), .en_fetch(en_fetch), .sig_pc_src(sig_pc_src),
    .imm_i(imm_i), .imm_j(imm_j), .push_ret(push_ret), .halt_req(halt_req),
    .pc(pc), .halted(halted), .ras_empty(ras_empty), .ras_full(ras_full),
    .ras_overflow(ras_overflow), .ras_underflow(ras_underflow)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic check_all(input string tag);
    check({tag, ".pc"}, pc, m_pc);
    check({tag, ".halted"}, 32'(halted), 32'(m_halt));
    check({tag, ".empty"}, 32'(ras_empty), 32'(m_q.size() == 0));
    check({tag, ".full"}, 32'(ras_full), 32'(m_q.size() == CAP));
    check({tag, ".ovf"}, 32'(ras_overflow), 32'(m_ovf));
    check({tag, ".unf"}, 32'(ras_underflow), 32'(m_unf));
  endtask

  task automatic step(input string tag, input bit rst_n, input bit en, input logic [1:0] src,
                      input logic [31:0] ii, input logic [31:0] ij, input bit push, input bit halt);
    logic [31:0] inc, nxt;
    @(negedge clock);
    reset_n = rst_n; en_fetch = en; sig_pc_src = src; imm_i = ii; imm_j = ij;
    push_ret = push; halt_req = halt;
    if (!rst_n) begin
      m_pc = 32'd0; m_halt = 0; m_ovf = 0; m_unf = 0; m_q.delete();
    end else if (en && !m_halt) begin
      inc = m_pc + 32'd1;
      if (src == 2'd0) nxt = inc;
      else if (src == 2'd1) nxt = m_pc + ii;
      else if (src == 2'd2) nxt = m_pc + ij;
      else if (m_q.size() > 0) nxt = m_q.pop_back();
      else begin nxt = inc; m_unf = 1; end
      if (push) begin
        if (m_q.size() == CAP) begin void'(m_q.pop_front()); m_ovf = 1; end
        m_q.push_back(inc);
      end
      m_pc = nxt;
      if (halt) m_halt = 1;
    end
    @(posedge clock);
    #1;
    check_all(tag);
  endtask

  task automatic fetch(input string tag, input logic [1:0] src, input logic [31:0] imm, input bit push, input bit halt);
    step(tag, 1, 1, src, imm, imm, push, halt);
  endtask

  task automatic idle(input string tag);
    step(tag, 1, 0, 2'($urandom), $urandom, $urandom, 1'($urandom), 1'($urandom));
  endtask

  task automatic jump_to(input logic [31:0] target);
    fetch("jump", 2'd1, target - m_pc, 0, 0);
  endtask

  initial begin
    step("reset", 0, 1, 2'd3, 32'd9, 32'd9, 1, 1);
    step("reset", 0, 0, 2'd0, 0, 0, 0, 0);
    check("reset.pc0", pc, 32'd0);
    for (int i = 1; i <= 3; i++) begin
      fetch("seq", 2'd0, 0, 0, 0);
      check("seq.val", pc, 32'(i));
      idle("hold");
      check("hold.val", pc, 32'(i));
    end
    fetch("br", 2'd1, 32'd7, 0, 0);
    fetch("br_back", 2'd1, 32'hFFFF_FFFC, 0, 0);
    check("br_back.val", pc, 32'd6);
    step("jmp", 1, 1, 2'd2, 32'd0, 32'h20, 0, 0);
    check("jmp.val", pc, 32'h26);
    jump_to(32'd5);
    step("call", 1, 1, 2'd2, 32'd0, 32'd100, 1, 0);
    check("call.val", pc, 32'd105);
    check("call.nonempty", 32'(ras_empty), 32'd0);
    fetch("ret", 2'd3, 0, 0, 0);
    check("ret.val", pc, 32'd6);
    check("ret.empty", 32'(ras_empty), 32'd1);
    for (int i = 0; i < CAP + 1; i++) fetch("push", 2'd0, 0, 1, 0);
    check("push.full", 32'(ras_full), 32'd1);
    check("push.ovf", 32'(ras_overflow), 32'd1);
    for (int i = 0; i < CAP; i++) fetch("pop", 2'd3, 0, 0, 0);
    fetch("pop_extra", 2'd3, 0, 0, 0);
    check("pop_extra.unf", 32'(ras_underflow), 32'd1);
    jump_to(32'd39);
    fetch("push40", 2'd0, 0, 1, 0);
    jump_to(32'd7);
    fetch("pushpop", 2'd3, 0, 1, 0);
    check("pushpop.val", pc, 32'd40);
    fetch("pop8", 2'd3, 0, 0, 0);
    check("pop8.val", pc, 32'd8);
    jump_to(32'hFFFF_FFFF);
    fetch("wrap", 2'd0, 0, 0, 0);
    check("wrap.val", pc, 32'd0);
    step("reset2", 0, 0, 2'd0, 0, 0, 0, 0);
    for (int i = 0; i < 400; i++) begin
      logic [31:0] imm;
      imm = 32'($signed($urandom_range(0, 200)) - 100);
      if ($urandom_range(0, 99) < 2) step("rnd_rst", 0, 1'($urandom), 2'($urandom), imm, imm, 1'($urandom), 0);
      else step("rnd", 1, $urandom_range(0, 9) < 7, 2'($urandom), imm, ~imm + 32'd1,
                $urandom_range(0, 9) < 3, 0);
    end
    step("reset3", 0, 0, 2'd0, 0, 0, 0, 0);
    jump_to(32'd3);
    fetch("halt", 2'd0, 0, 0, 1);
    check("halt.val", pc, 32'd4);
    check("halt.flag", 32'(halted), 32'd1);
    for (int i = 0; i < 4; i++) begin
      step("halted", 1, 1, 2'($urandom), $urandom, $urandom, 1, 0);
      check("halted.val", pc, 32'd4);
    end
    step("rst_halt", 0, 1, 2'd1, 32'd50, 32'd50, 1, 1);
    check("rst_halt.pc", pc, 32'd0);
    check("rst_halt.flag", 32'(halted), 32'd0);
    fetch("after", 2'd0, 0, 0, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/pc_fetch_unit.md
# pc_fetch_unit

Program-counter sequencer for the instruction-fetch stage. It holds the architectural PC that addresses instruction memory and advances it once per fetch-enable pulse from the control unit: sequential, I-type relative branch, J-type relative jump, or return. Return addresses come from an internal return-address stack, which replaces the external return-address register. The unit also freezes the PC once the program signals stop.

## Interface
- `PC_RESET`, default 0: PC value loaded on reset (word address).
- `RAS_DEPTH`, default 8: return-stack entries; must be a power of two, at least 2.

- `clock`  in  1  system clock; all state updates on the rising edge.
- `reset_n`  in  1  synchronous, active-low reset.
- `en_fetch`  in  1  fetch-stage enable from the control unit; one-cycle pulse.
- `sig_pc_src`  in  2  next-PC select: 00 = PC+1, 01 = PC+imm_i, 10 = PC+imm_j, 11 = return (pop).
- `imm_i`  in  32  sign-extended I-type immediate.
- `imm_j`  in  32  sign-extended J-type immediate.
- `push_ret`  in  1  call: push PC+1 onto the return stack.
- `halt_req`  in  1  stop bit of the current instruction.
- `pc`  out  32  current PC, registered.
- `halted`  out  1  unit is in HALT.
- `ras_empty`  out  1  stack holds 0 entries.
- `ras_full`  out  1  stack holds `RAS_DEPTH` entries.
- `ras_overflow`  out  1  sticky: a push occurred while full.
- `ras_underflow`  out  1  sticky: a pop occurred while empty.

## Operation
- **FSM states:** RUN and HALT. Reset enters RUN. From RUN, `en_fetch` & `halt_req` moves to HALT. HALT is left only by reset.
- **Event definition:** state changes only on an edge with `en_fetch`=1 in RUN. All other edges hold every register.
- **Next PC, by `sig_pc_src`:**
  - 00: PC+1.
  - 01: PC+`imm_i`.
  - 10: PC+`imm_j`.
  - 11: top of stack.
- **Arithmetic:** 32-bit two's-complement, modulo 2^32. 0xFFFFFFFF+1 wraps to 0. Negative immediates branch backward.
- **PC base:** the PC used in every sum and in the push is the value before the update.
- **Push:** writes PC+1 at the stack pointer and increments the pointer.
- **Pop:** decrements the pointer and returns that entry.
- **Push and pop together** (`push_ret`=1, `sig_pc_src`=11):
  - Pop first, then push into the freed slot.
  - Next PC is the old top; the top becomes PC+1.
  - Depth is unchanged; no flags change.
- **Push when full:**
  - The pointer wraps and overwrites the oldest entry.
  - Depth stays `RAS_DEPTH` and `ras_overflow` is set.
- **Pop when empty:**
  - Next PC is PC+1 and the pointer is unchanged.
  - `ras_underflow` is set.
- **Halt event:** when `halt_req` is set, PC, stack and flags still update as normal, then the state moves to HALT.
- **In HALT:** `pc` is frozen, and `en_fetch`, `push_ret` and `sig_pc_src` are ignored.

## Timing
- **Reset values:**
  - `pc`=`PC_RESET`, `halted`=0, `ras_empty`=1, `ras_full`=0, `ras_overflow`=0, `ras_underflow`=0.
  - Stack pointer = 0. Stack contents are don't-care.
- **Reset priority:** reset overrides everything on the same edge, including mid-halt and mid-push.
- **Latency:** one cycle. `pc` shows its new value after the edge on which `en_fetch`=1 was sampled.
- **Output registers:** `halted`, `ras_empty` and `ras_full` are registered and update on the same edge as `pc`.
- **Combinational paths:** none from inputs to outputs.
- **`en_fetch` held high:** the unit advances on every cycle it stays high. This is legal, but the control unit normally pulses it.

## Configuration
- **`PC_FETCH_RAS_EN` defined:** full `RAS_DEPTH`-entry stack, as described above.
- **`PC_FETCH_RAS_EN` undefined:** a single link register plus a valid bit replaces the stack.
  - Push writes PC+1 and sets valid.
  - Pop reads the link register and clears valid.
  - Push while valid overwrites and sets `ras_overflow`.
  - `ras_full` equals valid; `ras_empty` equals not valid.
  - `RAS_DEPTH` is ignored.
  - All other behaviour is identical.

## Test plan
- **Reset and sequential fetch:** reset with `PC_RESET`=0, then 3 pulses with src=00 → `pc` = 1, 2, 3. `pc` holds between pulses.
- **Branch and jump:**
  - At PC=10, src=01 with `imm_i`=0xFFFFFFFC → `pc`=6.
  - Then src=10 with `imm_j`=0x20 → `pc`=0x26.
- **Call and return:**
  - At PC=5, `push_ret` with src=10 and `imm_j`=100 → `pc`=105, stack top 6, `ras_empty`=0.
  - Then src=11 → `pc`=6, `ras_empty`=1.
- **Stack boundaries:**
  - 9 pushes with `RAS_DEPTH`=8 → `ras_full`=1, `ras_overflow`=1.
  - 8 pops return the newest 8 addresses.
  - A 9th pop → `pc`=PC+1, `ras_underflow`=1.
- **Simultaneous push and pop:** top=40 and PC=7 → `pc`=40, new top=8, depth unchanged.
- **Halt, then reset mid-halt:**
  - `halt_req` with src=00 at PC=3 → `pc`=4, `halted`=1.
  - Further pulses leave `pc`=4.
  - `reset_n`=0 for one edge → `pc`=0, `halted`=0.
